sample_serializer: RTL and testbench

SAMPLE_SERIALIZER -- requirements
Module: sample_serializer

---
 rtl/sample_serializer.sv | 101 ++++++++++
 tb/tb_sample_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_serializer.sv
// -----------------------------------------------------------------------------
// sample_serializer
//
// Purpose:
//    Turns one 16-bit PCM word per frame into a left-justified serial stream
//    for an audio codec. The same word is sent in the left slot and again in
//    the right slot (mono). The block also produces the codec bit clock, the
//    channel-select clock and a one-clk request pulse for the sample producer.
//
// Parameters:
//    sim       1 = fast bit clock for simulation, 0 = hardware bit clock
//
// Ports:
//    clk       input   system clock, all state changes on its rising edge
//    reset     input   asynchronous active-low reset (0 = in reset)
//    sample    input   signed 16-bit PCM word, captured only at frame load
//    play      input   1 = transmit sample, 0 = send silence; captured at load
//    NewFrame  output  one-clk pulse asking the producer for the next sample
//    bclk      output  serial bit clock
//    lrck      output  channel select, 0 = left slot, 1 = right slot
//    sdata     output  serial data, MSB first
// -----------------------------------------------------------------------------
module sample_serializer #(
   parameter bit sim = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [15:0] sample,
   input  logic               play,
   output logic               NewFrame,
   output logic               bclk,
   output logic               lrck,
   output logic               sdata
);

   // Number of clk cycles in each half-period of bclk.
   localparam int DIV = sim ? 2 : 8;

   logic [3:0]  div_cnt;
   logic [4:0]  bit_cnt;
   logic [15:0] hold_reg;
   logic [15:0] shift_reg;
   logic        nf_pending;

   logic        div_wrap;
   logic        falling_event;
   logic [4:0]  next_bit;

   // bclk toggles whenever the divider wraps; when it was high at that moment
   // this cycle is the bclk falling event that advances the serial state.
   assign div_wrap      = (div_cnt == 4'(DIV - 1));
   assign falling_event = div_wrap & bclk;
   assign next_bit      = bit_cnt + 5'd1;

   // Data is taken straight from the shift register MSB, so the first bit of
   // each slot appears together with the lrck edge (left-justified format).
   assign sdata = shift_reg[15];

   // Bit counter starts at 31 so the very first falling event after reset is
   // a frame load. NewFrame is delayed through nf_pending so that it appears
   // one clk after lrck rises; reset clears the pending flag, which is what
   // prevents a stray request pulse when a frame is aborted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt    <= '0;
         bclk       <= 1'b0;
         bit_cnt    <= 5'd31;
         lrck       <= 1'b0;
         hold_reg   <= '0;
         shift_reg  <= '0;
         nf_pending <= 1'b0;
         NewFrame   <= 1'b0;
      end else begin
         NewFrame   <= nf_pending;
         nf_pending <= 1'b0;

         if (div_wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
         end else begin
            div_cnt <= div_cnt + 4'd1;
         end

         if (falling_event) begin
            bit_cnt <= next_bit;
            if (next_bit == 5'd0) begin
               hold_reg  <= play ? sample : 16'h0000;
               shift_reg <= play ? sample : 16'h0000;
               lrck      <= 1'b0;
            end else if (next_bit == 5'd16) begin
               shift_reg  <= hold_reg;
               lrck       <= 1'b1;
               nf_pending <= 1'b1;
            end else begin
               shift_reg <= {shift_reg[14:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: tb/tb_sample_serializer.sv
// -----------------------------------------------------------------------------
// tb_sample_serializer
//
// Purpose:
//    Directed self-checking bench for sample_serializer with the fast
//    (sim = 1) bit clock: 4 clks per bclk period, 128 clks per frame.
//
// Ports:
//    none (top-level bench)
// -----------------------------------------------------------------------------
module tb_sample_serializer;

   logic               clk;
   logic               reset;
   logic signed [15:0] sample;
   logic               play;
   logic               NewFrame;
   logic               bclk;
   logic               lrck;
   logic               sdata;

   int checks;
   int failures;

   sample_serializer #(.sim(1'b1)) dut (
      .clk      (clk),
      .reset    (reset),
      .sample   (sample),
      .play     (play),
      .NewFrame (NewFrame),
      .bclk     (bclk),
      .lrck     (lrck),
      .sdata    (sdata)
   );

   // 10 time-unit system clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Drives the producer-side inputs.
   task automatic applyStimulus(input logic [15:0] s, input logic p);
      sample = s;
      play   = p;
   endtask

   // Advances one clk and samples just after the rising edge.
   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   // Starting 1 time unit after a frame-load edge, walks one full frame
   // (128 clks), collecting both slots, lrck errors at each bit point,
   // NewFrame pulses and bclk toggles. Optionally changes the inputs at
   // cycle change_at. Returns 1 time unit after the next frame-load edge.
   task automatic readFrame(input int change_at, input logic [15:0] new_sample,
                            input logic new_play,
                            output logic [15:0] left, output logic [15:0] right,
                            output int nf_count, output int nf_pos,
                            output int lr_err, output int toggles);
      logic prev_bclk;
      int   b;
      left      = '0;
      right     = '0;
      nf_count  = 0;
      nf_pos    = -1;
      lr_err    = 0;
      toggles   = 0;
      prev_bclk = bclk;
      for (int c = 0; c < 128; c++) begin
         if (c % 4 == 0) begin
            b = c / 4;
            if (b < 16) begin
               left[15 - b] = sdata;
               if (lrck !== 1'b0) lr_err++;
            end else begin
               right[31 - b] = sdata;
               if (lrck !== 1'b1) lr_err++;
            end
         end
         if (NewFrame === 1'b1) begin
            nf_count++;
            nf_pos = c;
         end
         if (c == change_at) applyStimulus(new_sample, new_play);
         stepEdge();
         if (bclk !== prev_bclk) toggles++;
         prev_bclk = bclk;
      end
   endtask

   // After reset release (done just after a falling clk edge), bclk must
   // rise on the 2nd clk and fall on the 4th, which is the first frame load.
   task automatic checkStartup(input string tag);
      stepEdge();
      checkOutput({tag, "_bclk_e1"}, 32'(bclk), 32'd0);
      stepEdge();
      checkOutput({tag, "_bclk_e2"}, 32'(bclk), 32'd1);
      stepEdge();
      checkOutput({tag, "_bclk_e3"}, 32'(bclk), 32'd1);
      checkOutput({tag, "_nf_e3"}, 32'(NewFrame), 32'd0);
      stepEdge();
      checkOutput({tag, "_bclk_e4"}, 32'(bclk), 32'd0);
      checkOutput({tag, "_lrck_e4"}, 32'(lrck), 32'd0);
   endtask

   // Main directed sequence.
   initial begin
      logic [15:0] exp_word [10];
      int          change_at [10];
      logic [15:0] change_sample [10];
      logic        change_play [10];
      logic [15:0] left;
      logic [15:0] right;
      int          nf_count;
      int          nf_pos;
      int          lr_err;
      int          toggles;

      checks   = 0;
      failures = 0;

      // Frame plan: A5C3 swapped to 1234 mid-frame, then FFFF muted at load
      // with play raised mid-frame, then free-running FFFF frames.
      exp_word  = '{16'hA5C3, 16'h1234, 16'h0000, 16'hFFFF, 16'hFFFF,
                    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      change_at = '{20, 20, 20, -1, -1, -1, -1, -1, -1, -1};
      change_sample = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0,
                        16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      change_play   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                        1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      reset = 1'b0;
      applyStimulus(16'hA5C3, 1'b1);

      repeat (3) stepEdge();
      checkOutput("rst_bclk", 32'(bclk), 32'd0);
      checkOutput("rst_lrck", 32'(lrck), 32'd0);
      checkOutput("rst_sdata", 32'(sdata), 32'd0);
      checkOutput("rst_newframe", 32'(NewFrame), 32'd0);

      @(negedge clk);
      reset = 1'b1;
      checkStartup("start");
      checkOutput("start_sdata_msb", 32'(sdata), 32'd1);

      for (int f = 0; f < 10; f++) begin
         readFrame(change_at[f], change_sample[f], change_play[f],
                   left, right, nf_count, nf_pos, lr_err, toggles);
         checkOutput($sformatf("f%0d_left", f), 32'(left), 32'(exp_word[f]));
         checkOutput($sformatf("f%0d_right", f), 32'(right), 32'(exp_word[f]));
         checkOutput($sformatf("f%0d_nf_count", f), 32'(nf_count), 32'd1);
         checkOutput($sformatf("f%0d_nf_pos", f), 32'(nf_pos), 32'd65);
         checkOutput($sformatf("f%0d_lrck_err", f), 32'(lr_err), 32'd0);
         checkOutput($sformatf("f%0d_bclk_toggles", f), 32'(toggles), 32'd64);
      end

      // Frame 11 has loaded FFFF; the new word only matters after reset.
      applyStimulus(16'h8001, 1'b1);
      repeat (82) stepEdge();
      checkOutput("pre_rst_bclk", 32'(bclk), 32'd1);
      checkOutput("pre_rst_lrck", 32'(lrck), 32'd1);
      checkOutput("pre_rst_sdata", 32'(sdata), 32'd1);

      // Asynchronous assertion, checked before any further clk edge.
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_bclk", 32'(bclk), 32'd0);
      checkOutput("async_lrck", 32'(lrck), 32'd0);
      checkOutput("async_sdata", 32'(sdata), 32'd0);
      checkOutput("async_newframe", 32'(NewFrame), 32'd0);

      repeat (2) stepEdge();
      @(negedge clk);
      reset = 1'b1;
      checkStartup("restart");

      readFrame(-1, 16'h0, 1'b1, left, right, nf_count, nf_pos, lr_err, toggles);
      checkOutput("rf_left", 32'(left), 32'h8001);
      checkOutput("rf_right", 32'(right), 32'h8001);
      checkOutput("rf_nf_count", 32'(nf_count), 32'd1);
      checkOutput("rf_nf_pos", 32'(nf_pos), 32'd65);
      checkOutput("rf_lrck_err", 32'(lr_err), 32'd0);
      checkOutput("rf_bclk_toggles", 32'(toggles), 32'd64);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
